// File: rtl/acl2_pkg.sv
// acl2_pkg
// Shared definitions for the ACL2 accelerometer sample sequencer and the
// SPI controller it drives: controller opcodes, ADXL-style register
// addresses, the POWER_CTL measurement value, the sequencer state
// enumeration and the axis selector with its address lookup.
package acl2_pkg;

  // Controller opcodes
  localparam logic [1:0] OP_REG_READ  = 2'b00;
  localparam logic [1:0] OP_FIFO_READ = 2'b01;
  localparam logic [1:0] OP_WRITE     = 2'b10;

  // Register addresses
  localparam logic [7:0] ADDR_X         = 8'h08;
  localparam logic [7:0] ADDR_Y         = 8'h09;
  localparam logic [7:0] ADDR_Z         = 8'h0A;
  localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

  // POWER_CTL value selecting measurement mode
  localparam logic [7:0] PWR_MEASURE = 8'h02;

  // Sequencer states; the INIT_* states are only reachable when the
  // power-up write is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_PUSH,
    ST_INIT_WR,
    ST_INIT_WAIT
  } seq_state_e;

  typedef enum logic [1:0] {
    AXIS_X,
    AXIS_Y,
    AXIS_Z
  } axis_e;

  function automatic logic [7:0] axis_addr(input axis_e axis);
    case (axis)
      AXIS_X:  return ADDR_X;
      AXIS_Y:  return ADDR_Y;
      AXIS_Z:  return ADDR_Z;
      default: return ADDR_X;
    endcase
  endfunction

endpackage

// File: rtl/acl2_sample_fifo.sv
// acl2_sample_fifo
// First-word fall-through FIFO holding packed {X, Y, Z} samples.
// rdata_o shows the head entry whenever empty_o is low (zero when empty).
// A push while full is accepted only if a pop happens in the same cycle.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, wdata_i   write request and data
//   pop_i             read request (ignored when empty)
//   rdata_o           head entry
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries (log2(DEPTH)+1 bits)
module acl2_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Storage is not reset, so hide it while empty.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/acl2_sample_sequencer.sv
// acl2_sample_sequencer
// Command stage in front of the ACL2 SPI controller. A free-running timer
// requests a sample every SAMPLE_DIVIDE cycles; each sample reads the X, Y
// and Z data registers, packs them as {X, Y, Z} and queues them in a small
// FWFT FIFO. A watchdog abandons a sample if the controller stalls.
// Optional build macro: ACL2_INIT_WRITE_EN -- after reset, write 0x02 to
// POWER_CTL (0x2D) before sampling starts. Undefined: no power-up write
// and SPI_WDATA is tied to 0.
// Ports:
//   CLK, RST                clock, asynchronous active-high reset
//   SPI_START               one-cycle transaction start to the controller
//   SPI_OPERATION/ADDRESS/WDATA  registered command fields
//   SPI_DONE, SPI_DATA      controller completion pulse and returned byte
//   SAMPLE_DATA/VALID/READY FWFT sample stream to the consumer
//   OVERFLOW, TIMEOUT_ERR   sticky error flags
//   CLEAR_FLAGS             clears both flags (a same-cycle set wins)
module acl2_sample_sequencer
  import acl2_pkg::*;
#(
  parameter int SAMPLE_DIVIDE = 100000,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        SPI_START,
  output logic [1:0]  SPI_OPERATION,
  output logic [7:0]  SPI_ADDRESS,
  output logic [7:0]  SPI_WDATA,
  input  logic        SPI_DONE,
  input  logic [7:0]  SPI_DATA,
  output logic [23:0] SAMPLE_DATA,
  output logic        SAMPLE_VALID,
  input  logic        SAMPLE_READY,
  output logic        OVERFLOW,
  output logic        TIMEOUT_ERR,
  input  logic        CLEAR_FLAGS
);

  localparam int TMR_W = $clog2(SAMPLE_DIVIDE + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

`ifdef ACL2_INIT_WRITE_EN
  localparam seq_state_e RESET_STATE = ST_INIT_WR;
`else
  localparam seq_state_e RESET_STATE = ST_IDLE;
`endif

  logic [TMR_W-1:0] timer_q;
  logic             tick;
  logic             pending_q;
  seq_state_e       state_q;
  axis_e            axis_q;
  logic [WD_W-1:0]  wd_q;
  logic             wd_expired;
  logic [7:0]       x_q, y_q, z_q;
  logic             start_q;
  logic [1:0]       op_q;
  logic [7:0]       addr_q;
  logic             timeout_err_q;
  logic             overflow_q;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow_evt;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

  // Sample timer: tick on the wrap from SAMPLE_DIVIDE-1 back to 0.
  assign tick = (timer_q == TMR_W'(SAMPLE_DIVIDE - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) timer_q <= '0;
    else     timer_q <= tick ? '0 : timer_q + TMR_W'(1);
  end

  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  // Sequencer FSM; all controller-facing outputs are registered here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= RESET_STATE;
      axis_q        <= AXIS_X;
      pending_q     <= 1'b0;
      wd_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      z_q           <= '0;
      start_q       <= 1'b0;
      op_q          <= '0;
      addr_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (CLEAR_FLAGS) timeout_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            pending_q <= 1'b0;
            axis_q    <= AXIS_X;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start_q <= 1'b1;
          op_q    <= OP_REG_READ;
          addr_q  <= axis_addr(axis_q);
          wd_q    <= '0;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (SPI_DONE) begin
            case (axis_q)
              AXIS_X: begin
                x_q     <= SPI_DATA;
                axis_q  <= AXIS_Y;
                state_q <= ST_ISSUE;
              end
              AXIS_Y: begin
                y_q     <= SPI_DATA;
                axis_q  <= AXIS_Z;
                state_q <= ST_ISSUE;
              end
              AXIS_Z: begin
                z_q     <= SPI_DATA;
                state_q <= ST_PUSH;
              end
              default: state_q <= ST_IDLE;
            endcase
          end else if (wd_expired) begin
            // Partial sample is simply abandoned; the next tick restarts at X.
            timeout_err_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        ST_PUSH: state_q <= ST_IDLE;
`ifdef ACL2_INIT_WRITE_EN
        ST_INIT_WR: begin
          start_q <= 1'b1;
          op_q    <= OP_WRITE;
          addr_q  <= ADDR_POWER_CTL;
          wd_q    <= '0;
          state_q <= ST_INIT_WAIT;
        end
        ST_INIT_WAIT: begin
          if (SPI_DONE) begin
            state_q <= ST_IDLE;
          end else if (wd_expired) begin
            timeout_err_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase

      // Placed after the FSM so a tick coinciding with IDLE consuming the
      // previous request is kept rather than lost.
      if (tick) pending_q <= 1'b1;
    end
  end

`ifdef ACL2_INIT_WRITE_EN
  logic [7:0] wdata_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      wdata_q <= '0;
    else if (state_q == ST_INIT_WR) wdata_q <= PWR_MEASURE;
    else if (state_q == ST_ISSUE)   wdata_q <= '0;
  end

  assign SPI_WDATA = wdata_q;
`else
  assign SPI_WDATA = '0;
`endif

  assign SPI_START     = start_q;
  assign SPI_OPERATION = op_q;
  assign SPI_ADDRESS   = addr_q;
  assign TIMEOUT_ERR   = timeout_err_q;

  // Sample FIFO
  assign fifo_push    = (state_q == ST_PUSH);
  assign fifo_pop     = SAMPLE_VALID && SAMPLE_READY;
  assign overflow_evt = fifo_push && fifo_full && !fifo_pop;

  acl2_sample_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (fifo_push),
    .wdata_i ({x_q, y_q, z_q}),
    .pop_i   (fifo_pop),
    .rdata_o (SAMPLE_DATA),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  assign SAMPLE_VALID = !fifo_empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               overflow_q <= 1'b0;
    else if (overflow_evt) overflow_q <= 1'b1;
    else if (CLEAR_FLAGS)  overflow_q <= 1'b0;
  end

  assign OVERFLOW = overflow_q;

endmodule

// File: doc/acl2_sample_sequencer.md
# acl2_sample_sequencer

Upstream command stage for the ACL2 accelerometer SPI controller. A timer starts each sample. On every sample the block runs three single-byte register reads (X, Y, Z). It packs the returned bytes into a 24-bit sample and buffers it in a small FIFO for the downstream consumer. It owns the controller's start/operation/address inputs and consumes its data/done outputs.

## Interface
- SAMPLE_DIVIDE, default 100000: CLK cycles between sample ticks.
- FIFO_DEPTH, default 4: sample FIFO entries; must be a power of two, at least 2.
- TIMEOUT, default 65535: CLK cycles allowed from SPI_START to SPI_DONE.

Ports:
- CLK  in  1  system clock; one clock domain only.
- RST  in  1  reset; asynchronous, active-high.
- SPI_START  out  1  one-cycle pulse that starts a controller transaction.
- SPI_OPERATION  out  2  opcode: 00 register read, 01 FIFO read, 10 write.
- SPI_ADDRESS  out  8  register address.
- SPI_WDATA  out  8  write data; used only for the write opcode.
- SPI_DONE  in  1  one-cycle pulse from the controller; SPI_DATA is valid in the same cycle.
- SPI_DATA  in  8  byte returned by the controller.
- SAMPLE_DATA  out  24  {X, Y, Z} at the FIFO head.
- SAMPLE_VALID  out  1  FIFO not empty.
- SAMPLE_READY  in  1  consumer accepts the head sample when SAMPLE_VALID is also high.
- OVERFLOW  out  1  sticky: a sample was dropped because the FIFO was full.
- TIMEOUT_ERR  out  1  sticky: SPI_DONE did not arrive within TIMEOUT cycles.
- CLEAR_FLAGS  in  1  clears OVERFLOW and TIMEOUT_ERR in the next cycle.

## Operation
- Reset values: all outputs 0, the FIFO is empty, the timer is 0, and the state is IDLE (or INIT_WR when the configuration feature is compiled in).
- Timer:
  - Counts 0 to SAMPLE_DIVIDE-1 and wraps.
  - On wrap it pulses an internal tick, which sets a single pending bit.
  - A tick while pending is already set is absorbed; ticks do not queue.
- State machine:
  - IDLE: if pending is set, clear it, set axis = X and go to ISSUE.
  - ISSUE: drive opcode 00 and address 0x08 / 0x09 / 0x0A for axis X / Y / Z, pulse SPI_START, go to WAIT_DONE.
  - WAIT_DONE: on SPI_DONE, latch SPI_DATA into the axis byte. After X or Y, advance the axis and return to ISSUE. After Z, go to PUSH.
  - PUSH: write {X, Y, Z} into the FIFO, then go to IDLE.
- SPI_OPERATION, SPI_ADDRESS and SPI_WDATA are registered. They stay stable from the SPI_START cycle through the SPI_DONE cycle.
- Timeout:
  - A watchdog counts cycles in WAIT_DONE.
  - At TIMEOUT the block sets TIMEOUT_ERR, discards the partial sample and goes to IDLE.
  - A later SPI_DONE that arrives while not in WAIT_DONE is ignored.
- FIFO:
  - First-word fall-through: SAMPLE_DATA shows the head whenever SAMPLE_VALID is high.
  - Pop occurs when SAMPLE_VALID and SAMPLE_READY are both high.
  - Push when full with no pop in the same cycle: the sample is dropped and OVERFLOW is set.
  - Push and pop in the same cycle while full: both succeed and OVERFLOW is not set.
  - Push into an empty FIFO: SAMPLE_VALID rises in the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH. The count register is log2(FIFO_DEPTH)+1 bits wide.
- Flags: if CLEAR_FLAGS and a new set event happen in the same cycle, set wins.
- Reset mid-transaction returns every output to its reset value immediately. The in-flight controller transaction is abandoned.

## Timing
- SPI_START is exactly one cycle wide, asserted in the cycle after ISSUE is entered.
- From SPI_DONE for Z to SAMPLE_VALID on an empty FIFO: 2 cycles (capture, then PUSH).
- Sample period: SAMPLE_DIVIDE cycles, provided three transactions plus overhead take less than that. Otherwise the effective rate drops to one sample per completed sequence.

## Configuration
- ACL2_INIT_WRITE_EN defined:
  - After reset the state machine enters INIT_WR and issues one write: opcode 10, address 0x2D (POWER_CTL), data 0x02 (measurement mode).
  - It waits for SPI_DONE, subject to the same timeout, then goes to IDLE.
  - Ticks that occur during INIT_WR set pending.
- ACL2_INIT_WRITE_EN undefined: INIT_WR does not exist, reset goes to IDLE, and SPI_WDATA is tied to 0.

## Structure
- Shared package acl2_pkg holds:
  - opcode constants OP_REG_READ, OP_FIFO_READ, OP_WRITE;
  - addresses ADDR_X 0x08, ADDR_Y 0x09, ADDR_Z 0x0A, ADDR_POWER_CTL 0x2D;
  - constant PWR_MEASURE 0x02;
  - the state enumeration.
- The controller also imports this package.
- Sub-module acl2_sample_fifo: the parameterised first-word fall-through FIFO with full, empty and count outputs.

## Test plan
- SAMPLE_DIVIDE=50 with a bench controller model returning 0x11, 0x22, 0x33 -> addresses 0x08, 0x09, 0x0A issued in order; SAMPLE_DATA = 0x112233.
- SAMPLE_READY held low for 5 samples at FIFO_DEPTH=4 -> 4 samples retained, OVERFLOW=1. Then CLEAR_FLAGS plus drain -> OVERFLOW=0 and samples come out in order.
- Controller model never returns SPI_DONE for Y at TIMEOUT=20 -> TIMEOUT_ERR=1 at cycle 20, no sample pushed, next tick restarts at X.
- RST asserted during WAIT_DONE for Y -> all outputs 0 asynchronously; after release, the first transaction is X.
- With ACL2_INIT_WRITE_EN defined, release reset -> first transaction is opcode 10, address 0x2D, data 0x02, and no register read is issued before its SPI_DONE.
